// File: rtl/seq_divider_8_bit.sv
// Sequential 8-bit restoring divider: one quotient bit per cycle, registered results.
// Define DIV_SIGNED_EN to build the two's-complement (signed) variant.
module seq_divider_8_bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] quotient,
    output logic [7:0] remainder,
    output logic       busy,
    output logic       done,
    output logic       div_zero,
    output logic       over_flow
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e     state_q;
    logic [7:0] rem_q;
    logic [7:0] dvd_q;
    logic [7:0] dsr_q;
    logic [2:0] cnt_q;

    logic [7:0] a_mag;
    logic [7:0] b_mag;
    logic [8:0] part;
    logic [8:0] diff;
    logic       no_borrow;
    logic [7:0] rem_nxt;
    logic [7:0] quo_nxt;
    logic [7:0] q_fix;
    logic [7:0] r_fix;
    logic       ov_fix;
    logic [7:0] div0_rem;

`ifdef DIV_SIGNED_EN
    logic       q_neg_q;
    logic       r_neg_q;
    logic [7:0] a_raw_q;

    // Magnitudes of two's-complement operands; 8'h80 maps to 128 unsigned.
    assign a_mag    = a[7] ? (~a + 8'd1) : a;
    assign b_mag    = b[7] ? (~b + 8'd1) : b;
    assign q_fix    = q_neg_q ? (~quo_nxt + 8'd1) : quo_nxt;
    assign r_fix    = r_neg_q ? (~rem_nxt + 8'd1) : rem_nxt;
    // Only a positive quotient of 128 (-128 / -1) is unrepresentable.
    assign ov_fix   = ~q_neg_q & quo_nxt[7];
    assign div0_rem = a_raw_q;
`else
    assign a_mag    = a;
    assign b_mag    = b;
    assign q_fix    = quo_nxt;
    assign r_fix    = rem_nxt;
    assign ov_fix   = 1'b0;
    assign div0_rem = dvd_q;
`endif

    // Partial remainder stays below 2*divisor, so the 9-bit difference sign is the borrow.
    assign part      = {rem_q, dvd_q[7]};
    assign diff      = part + ~{1'b0, dsr_q} + 9'd1;
    assign no_borrow = ~diff[8];
    assign rem_nxt   = no_borrow ? diff[7:0] : part[7:0];
    assign quo_nxt   = {dvd_q[6:0], no_borrow};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            rem_q     <= 8'd0;
            dvd_q     <= 8'd0;
            dsr_q     <= 8'd0;
            cnt_q     <= 3'd0;
            quotient  <= 8'd0;
            remainder <= 8'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            over_flow <= 1'b0;
`ifdef DIV_SIGNED_EN
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            a_raw_q   <= 8'd0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        rem_q     <= 8'd0;
                        dvd_q     <= a_mag;
                        dsr_q     <= b_mag;
                        cnt_q     <= 3'd0;
                        quotient  <= 8'd0;
                        remainder <= 8'd0;
                        div_zero  <= 1'b0;
                        over_flow <= 1'b0;
                        busy      <= 1'b1;
                        state_q   <= (b == 8'd0) ? StDone : StCalc;
`ifdef DIV_SIGNED_EN
                        q_neg_q   <= a[7] ^ b[7];
                        r_neg_q   <= a[7];
                        a_raw_q   <= a;
`endif
                    end
                end
                StCalc: begin
                    rem_q <= rem_nxt;
                    dvd_q <= quo_nxt;
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_q   <= StDone;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= q_fix;
                        remainder <= r_fix;
                        over_flow <= ov_fix;
                        div_zero  <= 1'b0;
                    end
                end
                StDone: begin
                    // busy still set here means we arrived straight from IDLE with b == 0.
                    if (busy) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= 8'hFF;
                        remainder <= div0_rem;
                        div_zero  <= 1'b1;
                        over_flow <= 1'b0;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/seq_divider_8_bit.md
SEQ_DIVIDER_8_BIT -- requirements
Module: seq_divider_8_bit

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request to divide; sampled only in IDLE.
REQ-005 a  input  8  dividend; captured when start is accepted.
REQ-006 b  input  8  divisor; captured when start is accepted.
REQ-007 quotient  output  8  registered result.
REQ-008 remainder  output  8  registered result.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse when results are valid.
REQ-011 div_zero  output  1  high when the last operation had b==0; held until the next accepted start.
REQ-012 over_flow  output  1  high when the signed quotient is unrepresentable; held until the next accepted start.

Function
REQ-013 FSM states SHALL be IDLE, CALC and DONE.
REQ-014 IDLE transitions:
- start=1 accepted in IDLE at edge k; a and b captured at that edge.
- b!=0: next state is CALC.
- b==0: next state is DONE.
REQ-015 CALC SHALL run exactly 8 restoring iterations, one per cycle, MSB first:
- shift {rem, dividend} left by one;
- trial-subtract the divisor from rem using 9-bit two's-complement add with the subtrahend inverted and carry-in 1;
- no borrow: keep the difference and set the quotient bit to 1;
- borrow: restore rem and set the quotient bit to 0.
REQ-016 An internal 3-bit iteration counter SHALL move CALC to DONE after the 8th iteration, with no wrap into a 9th iteration.
REQ-017 Handshake timing (normal case):
- busy = 1 in cycles k+1 .. k+8;
- done = 1 only in cycle k+9;
- the FSM returns to IDLE in cycle k+10.
REQ-018 Handshake timing (b==0 case):
- busy = 1 in cycle k+1 only;
- done = 1 in cycle k+2.
REQ-019 quotient, remainder, div_zero and over_flow SHALL update together, on the edge that enters DONE.
REQ-020 These outputs SHALL hold their values through IDLE until the next accepted start.
REQ-021 Once start is accepted, quotient, remainder, div_zero and over_flow SHALL be cleared to 0 on the next edge.
REQ-022 start while busy or in DONE SHALL be ignored; it SHALL NOT be queued.
REQ-023 start held high continuously SHALL begin a new operation on the first IDLE edge after DONE.
REQ-024 Divide-by-zero result: quotient=8'hFF, remainder=a, div_zero=1, over_flow=0.
REQ-025 Unsigned result:
- a < b gives quotient=0, remainder=a;
- a == b gives quotient=1, remainder=0.

Reset
REQ-026 While rst_n=0 at a clock edge, the module SHALL:
- set state to IDLE;
- clear the iteration counter and all datapath registers;
- drive quotient=0, remainder=0, busy=0, done=0, div_zero=0, over_flow=0.
REQ-027 Reset mid-CALC SHALL abort the operation without producing a done pulse.
REQ-028 After reset deasserts, the first start SHALL be accepted on the next edge.

Configuration
REQ-029 Macro DIV_SIGNED_EN SHALL compile in the signed mode.
REQ-030 Without DIV_SIGNED_EN:
- a and b are unsigned;
- over_flow is tied to 0;
- latency is as stated in REQ-017 and REQ-018.
REQ-031 With DIV_SIGNED_EN, operand handling:
- a and b are two's complement;
- magnitudes are formed at capture;
- the unsigned core operates on those magnitudes.
REQ-032 With DIV_SIGNED_EN, result signs:
- quotient is negated when a[7]^b[7];
- remainder takes the sign of a.
REQ-033 With DIV_SIGNED_EN, sign fix-up SHALL occur on the DONE entry edge, so latency equals unsigned mode.
REQ-034 With DIV_SIGNED_EN, a=8'h80 and b=8'hFF SHALL give quotient=8'h80, remainder=0, over_flow=1.
REQ-035 With DIV_SIGNED_EN, b==0 SHALL give the same result as REQ-024.

Verification
REQ-036 Unsigned a=100, b=7, start at edge k -> quotient=14, remainder=2, done only in cycle k+9, busy in k+1..k+8.
REQ-037 a=200, b=0 -> done in cycle k+2, quotient=8'hFF, remainder=200, div_zero=1.
REQ-038 a=5, b=9, then start pulsed in cycle k+4 -> quotient=0, remainder=5, and no second operation starts.
REQ-039 rst_n=0 in cycle k+5 during a=255, b=3 -> all outputs 0, no done pulse, next start for 255/3 gives quotient=85, remainder=0.
REQ-040 DIV_SIGNED_EN, a=-7 (8'hF9), b=2 -> quotient=-3 (8'hFD), remainder=-1 (8'hFF).
REQ-041 DIV_SIGNED_EN, a=8'h80, b=8'hFF -> quotient=8'h80, remainder=0, over_flow=1.
